// File: rtl/regfile_scoreboard.sv
// 32-entry MIPS register file with write-through bypass reads and a per-register
// busy scoreboard that stalls issue on RAW/WAW hazards against outstanding write-backs.
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    rs_addr,
    input  logic [ADDR_W-1:0]    rt_addr,
    output logic [DATA_W-1:0]    rs_data,
    output logic [DATA_W-1:0]    rt_data,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 issue_valid,
    input  logic                 issue_uses_rs,
    input  logic                 issue_uses_rt,
    input  logic                 issue_wr,
    input  logic [ADDR_W-1:0]    issue_dest,
    output logic                 stall,
    output logic [2**ADDR_W-1:0] busy_mask
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic rsBypass;
    logic rtBypass;
    logic destBypass;
    logic rsHazard;
    logic rtHazard;
    logic wawHazard;
    logic doSet;

    // A same-cycle write-back to the read address supplies the data, so it both
    // bypasses the array and cancels the hazard on that register.
    assign rsBypass   = wr_en && (wr_addr == rs_addr);
    assign rtBypass   = wr_en && (wr_addr == rt_addr);
    assign destBypass = wr_en && (wr_addr == issue_dest);

    assign rs_data = (rs_addr == ZERO_ADDR) ? '0 : (rsBypass ? wr_data : regs_q[rs_addr]);
    assign rt_data = (rt_addr == ZERO_ADDR) ? '0 : (rtBypass ? wr_data : regs_q[rt_addr]);

    assign rsHazard  = issue_uses_rs && (rs_addr != ZERO_ADDR) && busy_q[rs_addr] && !rsBypass;
    assign rtHazard  = issue_uses_rt && (rt_addr != ZERO_ADDR) && busy_q[rt_addr] && !rtBypass;
    assign wawHazard = issue_wr && (issue_dest != ZERO_ADDR) && busy_q[issue_dest] && !destBypass;

    assign stall = issue_valid && (rsHazard || rtHazard || wawHazard);
    assign doSet = issue_valid && !stall && issue_wr && (issue_dest != ZERO_ADDR);

    // Clear is applied before set so a new producer on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (doSet) begin
            busy_d[issue_dest] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            if (wr_en && (wr_addr != ZERO_ADDR)) begin
                regs_q[wr_addr] <= wr_data;
            end
        end
    end

    assign busy_mask = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized checks of regfile_scoreboard: bypass reads, r0 handling,
// RAW/WAW stalls, set-over-clear priority, asynchronous reset, and a reference-model run.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_valid;
    logic        issue_uses_rs;
    logic        issue_uses_rt;
    logic        issue_wr;
    logic [4:0]  issue_dest;
    logic        stall;
    logic [31:0] busy_mask;

    int nCompared;
    int nMismatched;

    logic [31:0] modelRegs [32];
    logic [31:0] modelBusy;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .issue_valid   (issue_valid),
        .issue_uses_rs (issue_uses_rs),
        .issue_uses_rt (issue_uses_rt),
        .issue_wr      (issue_wr),
        .issue_dest    (issue_dest),
        .stall         (stall),
        .busy_mask     (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic urs, input logic urt,
                                 input logic iw, input logic [4:0] dest,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
        issue_valid   = iv;
        issue_uses_rs = urs;
        issue_uses_rt = urt;
        issue_wr      = iw;
        issue_dest    = dest;
        wr_en         = we;
        wr_addr       = wa;
        wr_data       = wd;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        logic [31:0] expRs;
        logic [31:0] expRt;
        logic        expStall;
        logic        hzRs;
        logic        hzRt;
        logic        hzWaw;

        nCompared   = 0;
        nMismatched = 0;
        rst_n   = 1'b0;
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        idle();
        #10;
        checkOutput("reset_busy", busy_mask, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Write r8 with same-cycle bypass, then read from the array.
        rs_addr = 5'd8;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 32'hDEAD_BEEF);
        checkOutput("bypass_r8", rs_data, 32'hDEAD_BEEF);
        tick();
        idle();
        checkOutput("stored_r8", rs_data, 32'hDEAD_BEEF);

        // r0 ignores writes, even during the bypass cycle.
        rt_addr = 5'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h0000_1234);
        checkOutput("r0_bypass", rt_data, 32'h0);
        tick();
        idle();
        checkOutput("r0_stored", rt_data, 32'h0);

        // RAW on rs: producer to r9, consumer stalls until the write-back cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
        checkOutput("issue9_stall", {31'b0, stall}, 32'h0);
        tick();
        checkOutput("busy9_set", busy_mask, 32'h0000_0200);
        rs_addr = 5'd9;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("raw_stall", {31'b0, stall}, 32'h1);
        tick();
        checkOutput("raw_busy_hold", busy_mask, 32'h0000_0200);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h0000_0055);
        checkOutput("raw_wb_nostall", {31'b0, stall}, 32'h0);
        checkOutput("raw_wb_bypass", rs_data, 32'h0000_0055);
        tick();
        idle();
        checkOutput("busy9_clear", busy_mask, 32'h0);

        // WAW on r5, then same-edge clear and set where the set must win.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("busy5_set", busy_mask, 32'h0000_0020);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0);
        checkOutput("waw_stall", {31'b0, stall}, 32'h1);
        tick();
        checkOutput("waw_busy_hold", busy_mask, 32'h0000_0020);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 32'h0000_0A05);
        checkOutput("waw_wb_nostall", {31'b0, stall}, 32'h0);
        tick();
        idle();
        checkOutput("set_wins", busy_mask, 32'h0000_0020);
        rs_addr = 5'd5;
        #1;
        checkOutput("r5_written", rs_data, 32'h0000_0A05);

        // rt hazard, issue_valid gating, and r0 never hazarding or becoming busy.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("busy3_set", busy_mask, 32'h0000_0028);
        rt_addr = 5'd3;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("rt_stall", {31'b0, stall}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("noissue_nostall", {31'b0, stall}, 32'h0);
        rt_addr = 5'd0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0);
        checkOutput("rt0_nostall", {31'b0, stall}, 32'h0);
        tick();
        checkOutput("dest0_not_busy", busy_mask, 32'h0000_0028);

        // Write a non-busy r4, then retire r3/r5 while issuing to r4/r8 -> busy 0x110.
        rs_addr = 5'd4;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 32'hA5A5_A5A5);
        tick();
        idle();
        checkOutput("r4_nonbusy_wr", rs_data, 32'hA5A5_A5A5);
        checkOutput("nonbusy_clear_noop", busy_mask, 32'h0000_0028);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 5'd3, 32'h0000_0033);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 5'd5, 32'h0000_5555);
        tick();
        idle();
        checkOutput("busy_pre_reset", busy_mask, 32'h0000_0110);

        // Asynchronous reset mid-cycle; a write attempted during reset must not land.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_busy", busy_mask, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 5'd8, 32'hFFFF_FFFF);
        tick();
        idle();
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("reset_r4", rs_data, 32'h0);
        rs_addr = 5'd8;
        #1;
        checkOutput("reset_r8_nowrite", rs_data, 32'h0);
        checkOutput("reset_busy_after", busy_mask, 32'h0);
        tick();

        // Randomized traffic against a reference model; small address range keeps hazards frequent.
        for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
        modelBusy = 32'h0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            rs_addr = 5'($urandom_range(0, 7));
            rt_addr = 5'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            expRs = (rs_addr == 5'd0) ? 32'h0 : ((wr_en && wr_addr == rs_addr) ? wr_data : modelRegs[rs_addr]);
            expRt = (rt_addr == 5'd0) ? 32'h0 : ((wr_en && wr_addr == rt_addr) ? wr_data : modelRegs[rt_addr]);
            hzRs  = issue_uses_rs && modelBusy[rs_addr] && !(wr_en && wr_addr == rs_addr);
            hzRt  = issue_uses_rt && modelBusy[rt_addr] && !(wr_en && wr_addr == rt_addr);
            hzWaw = issue_wr && modelBusy[issue_dest] && !(wr_en && wr_addr == issue_dest);
            expStall = issue_valid && (hzRs || hzRt || hzWaw);
            checkOutput("rand_rs_data", rs_data, expRs);
            checkOutput("rand_rt_data", rt_data, expRt);
            checkOutput("rand_stall", {31'b0, stall}, {31'b0, expStall});
            if (wr_en && wr_addr != 5'd0) modelRegs[wr_addr] = wr_data;
            if (wr_en) modelBusy[wr_addr] = 1'b0;
            if (issue_valid && !expStall && issue_wr && issue_dest != 5'd0) modelBusy[issue_dest] = 1'b1;
            tick();
            checkOutput("rand_busy_mask", busy_mask, modelBusy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
